// File: rtl/imem_loader_pkg.sv
// Purpose  : shared constants and FSM encoding for the instruction-memory loader.
// Latency  : n/a (declarations only).
// Backpres.: n/a.
// Contents : TEXT_BASE (text segment base, also used by the fetch-side ROM map),
//            BYTE_W (byte-lane width), state encoding.
package imem_loader_pkg;

    localparam logic [31:0] TEXT_BASE = 32'h0040_0000;
    localparam int          BYTE_W    = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RECV  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        RECV  = ST_RECV,
        WRITE = ST_WRITE,
        DONE  = ST_DONE
    } state_e;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Purpose  : packs pushed bytes little-endian into a word (byte k -> lane k).
// Latency  : word/full reflect the current push combinationally; state updates next edge.
// Backpres.: none; the caller only pushes when it can accept a byte.
// Ports    : clk, reset (async, active-high), clear (restart at lane 0), push,
//            byte_i (pushed byte), word (packed word including this push),
//            full (this push completes the word).
module byte_packer
    import imem_loader_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              push,
    input  logic [BYTE_W-1:0] byte_i,
    output logic [WORD_W-1:0] word,
    output logic              full
);

    localparam int LANES = WORD_W / BYTE_W;
    localparam int CNT_W = $clog2(LANES);

    logic [CNT_W-1:0]  cnt_q;
    logic [WORD_W-1:0] lanes_q;

    // Merge the incoming byte into its lane so the owner can capture the
    // finished word on the same edge that accepts the last byte.
    always_comb begin
        word = lanes_q;
        if (push) begin
            word[int'(cnt_q)*BYTE_W +: BYTE_W] = byte_i;
        end
        full = push && (cnt_q == CNT_W'(LANES - 1));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            lanes_q <= '0;
        end else if (clear) begin
            cnt_q   <= '0;
        end else if (push) begin
            lanes_q <= word;
            cnt_q   <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Purpose  : loads a byte stream into instruction RAM as LE 32-bit words from BASE_ADDR, holding the CPU.
// Latency  : write strobe the cycle after the 4th byte; 5 cycles/word at full rate, then a 1-cycle done.
// Backpres.: byte_ready only in RECV; byte_valid stalls RECV indefinitely.
// Ports    : clk, reset (async, active-high); start/len load request; byte_data/_valid/_ready
//            stream; mem_we/mem_addr/mem_wdata RAM write port; busy, cpu_hold, done, err status.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    MEM_DEPTH  = 64,
    parameter logic [DATA_WIDTH-1:0] BASE_ADDR  = TEXT_BASE
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [$clog2(MEM_DEPTH):0]   len,
    input  logic [7:0]                   byte_data,
    input  logic                         byte_valid,
    output logic                         byte_ready,
    output logic                         mem_we,
    output logic [DATA_WIDTH-1:0]        mem_addr,
    output logic [DATA_WIDTH-1:0]        mem_wdata,
    output logic                         busy,
    output logic                         cpu_hold,
    output logic                         done,
    output logic                         err
);

    localparam int LEN_W = $clog2(MEM_DEPTH) + 1;
    localparam int IDX_W = $clog2(MEM_DEPTH);

    state_e                  state_q, state_d;
    logic [LEN_W-1:0]        len_q, len_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [DATA_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    err_q, err_d;

    logic                    pk_clear, pk_push, pk_full;
    logic [DATA_WIDTH-1:0]   pk_word;
    logic                    last_word;

    byte_packer #(.WORD_W(DATA_WIDTH)) u_packer (
        .clk    (clk),
        .reset  (reset),
        .clear  (pk_clear),
        .push   (pk_push),
        .byte_i (byte_data),
        .word   (pk_word),
        .full   (pk_full)
    );

    assign last_word = (LEN_W'({1'b0, idx_q}) + LEN_W'(1)) == len_q;

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        idx_d    = idx_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        err_d    = err_q;
        pk_clear = 1'b0;
        pk_push  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (len != '0 && len <= LEN_W'(MEM_DEPTH)) begin
                        len_d    = len;
                        idx_d    = '0;
                        pk_clear = 1'b1;
                        err_d    = 1'b0;
                        state_d  = RECV;
                    end else begin
                        err_d    = 1'b1;
                        state_d  = DONE;
                    end
                end
            end
            RECV: begin
                pk_push = byte_valid;
                // Capture the port values on the accepting edge so the
                // write strobe cycle sees them from registers.
                if (pk_full) begin
                    wdata_d = pk_word;
                    addr_d  = BASE_ADDR + (DATA_WIDTH'(idx_q) << 2);
                    state_d = WRITE;
                end
            end
            WRITE: begin
                pk_clear = 1'b1;
                // Index stays put on the final word so it never reaches MEM_DEPTH.
                if (last_word) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = RECV;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            len_q   <= '0;
            idx_q   <= '0;
            addr_q  <= BASE_ADDR;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

    assign byte_ready = (state_q == RECV);
    assign mem_we     = (state_q == WRITE);
    assign busy       = (state_q != IDLE);
    assign cpu_hold   = busy;
    assign done       = (state_q == DONE);
    assign err        = err_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;

endmodule

// File: tb/tb_imem_loader.sv
// Purpose  : scoreboard bench for imem_loader; expected writes queued by stimulus, popped by a monitor.
// Latency  : n/a.
// Backpres.: byte driver waits on byte_ready with a bounded wait.
module tb_imem_loader;

    localparam logic [31:0] BASE = 32'h0040_0000;

    logic        clk;
    logic        reset;
    logic        start;
    logic [6:0]  len;
    logic [7:0]  byte_data;
    logic        byte_valid;
    logic        byte_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        cpu_hold;
    logic        done;
    logic        err;

    imem_loader dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .len        (len),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];

    int          checks = 0;
    int          failures = 0;
    int          wr_cnt = 0;
    int          last_we_cyc = 0;
    int          last_done_cyc = 0;
    int          busy_run = 0;
    int          last_busy = 0;
    logic [31:0] last_addr = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic [31:0] a, input logic [31:0] d);
        exp_addr_q.push_back(a);
        exp_data_q.push_back(d);
    endtask

    // Monitor: pops the scoreboard on every write strobe.
    always @(negedge clk) begin
        logic [31:0] ea, ed;
        chk("cpu_hold_eq_busy", {31'b0, cpu_hold}, {31'b0, busy});
        if (mem_we) begin
            wr_cnt++;
            last_we_cyc = cyc;
            last_addr   = mem_addr;
            chk("ready_low_in_write", {31'b0, byte_ready}, 32'd0);
            if (exp_addr_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write actual=%h/%h required=none", mem_addr, mem_wdata);
            end else begin
                ea = exp_addr_q.pop_front();
                ed = exp_data_q.pop_front();
                chk("wr_addr", mem_addr, ea);
                chk("wr_data", mem_wdata, ed);
            end
        end
        if (done) last_done_cyc = cyc;
        if (busy) begin
            busy_run++;
        end else if (busy_run != 0) begin
            last_busy = busy_run;
            busy_run  = 0;
        end
    end

    // Called at posedge+1 while in IDLE; returns at posedge+1 after the start edge.
    task automatic do_start(input logic [6:0] l);
        start = 1'b1;
        len   = l;
        @(posedge clk); #1;
        start = 1'b0;
        len   = 7'h55;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        n = 0;
        if (gap > 0) begin
            byte_valid = 1'b0;
            repeat (gap) @(posedge clk);
            #1;
        end
        byte_data  = b;
        byte_valid = 1'b1;
        @(negedge clk);
        while (!byte_ready && n < 500) begin
            n++;
            @(negedge clk);
        end
        if (!byte_ready) begin
            checks++;
            failures++;
            $display("FAIL byte_accept_timeout actual=no_ready required=ready byte=%h", b);
            byte_valid = 1'b0;
        end else begin
            @(posedge clk); #1;
            byte_valid = 1'b0;
        end
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int k = 0; k < 4; k++) begin
            send_byte(w[8*k +: 8], gap);
        end
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!done && n < 1000) begin
            n++;
            @(negedge clk);
        end
        chk({name, "_done_seen"}, {31'b0, done}, 32'd1);
        @(negedge clk);
        chk({name, "_done_one_cycle"}, {31'b0, done}, 32'd0);
        chk({name, "_busy_after"}, {31'b0, busy}, 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        reset = 1'b1; start = 1'b0; len = 7'd0; byte_data = 8'd0; byte_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_byte_ready", {31'b0, byte_ready}, 32'd0);
        chk("rst_mem_we",     {31'b0, mem_we},     32'd0);
        chk("rst_busy",       {31'b0, busy},       32'd0);
        chk("rst_cpu_hold",   {31'b0, cpu_hold},   32'd0);
        chk("rst_done",       {31'b0, done},       32'd0);
        chk("rst_err",        {31'b0, err},        32'd0);
        chk("rst_mem_addr",   mem_addr,  BASE);
        chk("rst_mem_wdata",  mem_wdata, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // len=2, continuous bytes.
        w0 = wr_cnt;
        push_exp(BASE,        32'h1234_5678);
        push_exp(BASE + 4,    32'hDEAD_BEEF);
        do_start(7'd2);
        send_word(32'h1234_5678, 0);
        send_word(32'hDEAD_BEEF, 0);
        wait_done("t1");
        chk("t1_writes",   wr_cnt - w0, 32'd2);
        chk("t1_busy_len", last_busy, 32'd11);
        chk("t1_done_lag", last_done_cyc - last_we_cyc, 32'd1);
        chk("t1_sb_empty", exp_addr_q.size(), 32'd0);

        // len=1, byte_valid toggling.
        w0 = wr_cnt;
        push_exp(BASE, 32'h4433_2211);
        do_start(7'd1);
        send_word(32'h4433_2211, 1);
        wait_done("t2");
        chk("t2_writes", wr_cnt - w0, 32'd1);

        // len=0 and len=MEM_DEPTH+1 are rejected.
        w0 = wr_cnt;
        do_start(7'd0);
        wait_done("t3a");
        chk("t3a_err", {31'b0, err}, 32'd1);
        chk("t3a_busy_len", last_busy, 32'd1);
        do_start(7'd65);
        wait_done("t3b");
        chk("t3b_err", {31'b0, err}, 32'd1);
        chk("t3_no_writes", wr_cnt - w0, 32'd0);
        push_exp(BASE, 32'h0403_0201);
        do_start(7'd1);
        chk("t3c_err_cleared", {31'b0, err}, 32'd0);
        send_word(32'h0403_0201, 0);
        wait_done("t3c");

        // Full-depth load.
        w0 = wr_cnt;
        for (int i = 0; i < 64; i++) push_exp(BASE + 32'(4 * i), 32'hFFFF_FFFF);
        do_start(7'd64);
        for (int i = 0; i < 64; i++) send_word(32'hFFFF_FFFF, 0);
        wait_done("t4");
        chk("t4_writes",    wr_cnt - w0, 32'd64);
        chk("t4_last_addr", last_addr, 32'h0040_00FC);
        chk("t4_busy_len",  last_busy, 32'd321);

        // Reset mid-load after 2 bytes of word 1.
        w0 = wr_cnt;
        push_exp(BASE, 32'hA3A2_A1A0);
        do_start(7'd3);
        send_word(32'hA3A2_A1A0, 0);
        send_byte(8'hB0, 0);
        send_byte(8'hB1, 0);
        reset = 1'b1;
        #1;
        chk("t5_byte_ready", {31'b0, byte_ready}, 32'd0);
        chk("t5_mem_we",     {31'b0, mem_we},     32'd0);
        chk("t5_busy",       {31'b0, busy},       32'd0);
        chk("t5_cpu_hold",   {31'b0, cpu_hold},   32'd0);
        chk("t5_done",       {31'b0, done},       32'd0);
        chk("t5_err",        {31'b0, err},        32'd0);
        chk("t5_mem_addr",   mem_addr,  BASE);
        chk("t5_mem_wdata",  mem_wdata, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        chk("t5_writes_before", wr_cnt - w0, 32'd1);
        push_exp(BASE, 32'h0D0C_0B0A);
        do_start(7'd1);
        send_word(32'h0D0C_0B0A, 0);
        wait_done("t5");
        chk("t5_writes", wr_cnt - w0, 32'd2);

        // start pulse during RECV is ignored.
        w0 = wr_cnt;
        push_exp(BASE,     32'h3322_1100);
        push_exp(BASE + 4, 32'h7766_5544);
        do_start(7'd2);
        send_byte(8'h00, 0);
        send_byte(8'h11, 0);
        start = 1'b1;
        len   = 7'd5;
        send_byte(8'h22, 0);
        start = 1'b0;
        send_byte(8'h33, 0);
        send_word(32'h7766_5544, 0);
        wait_done("t6");
        chk("t6_writes",   wr_cnt - w0, 32'd2);
        chk("t6_busy_len", last_busy, 32'd11);
        chk("final_sb_empty", exp_addr_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
